// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Purpose:
//   Shares one simple-dual-port block RAM (one read port, one write port,
//   1-cycle registered read, write-to-read forwarding on the same address)
//   between two requesters. Each cycle at most one read and at most one write
//   is granted. Each port has its own round-robin priority pointer. Read data
//   is routed back to the requester that issued the read, one cycle after the
//   grant.
//
// Ports:
//   clock                   single clock, rising-edge
//   reset                   synchronous, active-high
//   req_valid_k/req_write_k requester k has an operation pending / 1 = write
//   req_addr_k/req_wdata_k  word address / write data of requester k
//   req_ready_k             grant; accepted this cycle when valid & ready
//   resp_valid_k            read data for requester k is valid this cycle
//   resp_rdata_k            read data (0 when resp_valid_k is low)
//   bram_read_*             BRAM read port (enable, address, data in)
//   bram_write_*            BRAM write port (enable, address, data)
//   conflict_count          saturating count of cycles in which two requests
//                           of the same kind competed
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req_valid_0,
    input  logic                  req_write_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    output logic                  req_ready_0,

    input  logic                  req_valid_1,
    input  logic                  req_write_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  req_ready_1,

    output logic                  resp_valid_0,
    output logic [DATA_WIDTH-1:0] resp_rdata_0,
    output logic                  resp_valid_1,
    output logic [DATA_WIDTH-1:0] resp_rdata_1,

    output logic                  bram_read_enable,
    output logic [ADDR_WIDTH-1:0] bram_read_address,
    input  logic [DATA_WIDTH-1:0] bram_read_data,

    output logic                  bram_write_enable,
    output logic [ADDR_WIDTH-1:0] bram_write_address,
    output logic [DATA_WIDTH-1:0] bram_write_data,

    output logic [CNT_WIDTH-1:0]  conflict_count
);

    // -------------------------------------------------------------------------
    // Requester fields gathered into indexable form
    // -------------------------------------------------------------------------
    logic [1:0]            valid_vec;
    logic [1:0]            write_vec;
    logic [ADDR_WIDTH-1:0] addr_arr  [2];
    logic [DATA_WIDTH-1:0] wdata_arr [2];

    assign valid_vec    = {req_valid_1, req_valid_0};
    assign write_vec    = {req_write_1, req_write_0};
    assign addr_arr[0]  = req_addr_0;
    assign addr_arr[1]  = req_addr_1;
    assign wdata_arr[0] = req_wdata_0;
    assign wdata_arr[1] = req_wdata_1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                 rd_pri_reg, rd_pri_next;
    logic                 wr_pri_reg, wr_pri_next;
    logic [1:0]           resp_pend_reg, resp_pend_next;
    logic [CNT_WIDTH-1:0] conflict_count_reg, conflict_count_next;

    // -------------------------------------------------------------------------
    // Request classification and grants
    // -------------------------------------------------------------------------
    logic [1:0] rd_req;
    logic [1:0] wr_req;
    logic [1:0] rd_gnt;
    logic [1:0] wr_gnt;
    logic [1:0] ready_vec;
    logic       conflict;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            // Requests are masked during reset so that no grant, enable or
            // conflict can be produced while the block is held in reset.
            assign rd_req[gi]    = valid_vec[gi] & ~write_vec[gi] & ~reset;
            assign wr_req[gi]    = valid_vec[gi] &  write_vec[gi] & ~reset;
            assign ready_vec[gi] = rd_gnt[gi] | wr_gnt[gi];
        end
    endgenerate

    // A lone requester always wins; under contention the pointer decides.
    assign rd_gnt[0] = rd_req[0] & (~rd_req[1] | ~rd_pri_reg);
    assign rd_gnt[1] = rd_req[1] & (~rd_req[0] |  rd_pri_reg);
    assign wr_gnt[0] = wr_req[0] & (~wr_req[1] | ~wr_pri_reg);
    assign wr_gnt[1] = wr_req[1] & (~wr_req[0] |  wr_pri_reg);

    assign conflict = (&rd_req) | (&wr_req);

    assign req_ready_0 = ready_vec[0];
    assign req_ready_1 = ready_vec[1];

    // -------------------------------------------------------------------------
    // BRAM port drive, straight from the current-cycle grant
    // -------------------------------------------------------------------------
    always_comb begin
        bram_read_enable   = 1'b0;
        bram_read_address  = '0;
        bram_write_enable  = 1'b0;
        bram_write_address = '0;
        bram_write_data    = '0;

        if (rd_gnt[0]) begin
            bram_read_enable  = 1'b1;
            bram_read_address = addr_arr[0];
        end else if (rd_gnt[1]) begin
            bram_read_enable  = 1'b1;
            bram_read_address = addr_arr[1];
        end

        if (wr_gnt[0]) begin
            bram_write_enable  = 1'b1;
            bram_write_address = addr_arr[0];
            bram_write_data    = wdata_arr[0];
        end else if (wr_gnt[1]) begin
            bram_write_enable  = 1'b1;
            bram_write_address = addr_arr[1];
            bram_write_data    = wdata_arr[1];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        rd_pri_next         = rd_pri_reg;
        wr_pri_next         = wr_pri_reg;
        resp_pend_next      = rd_gnt;
        conflict_count_next = conflict_count_reg;

        // The winner hands priority to the other requester, even when it
        // won uncontested.
        if (rd_gnt[0]) begin
            rd_pri_next = 1'b1;
        end else if (rd_gnt[1]) begin
            rd_pri_next = 1'b0;
        end

        if (wr_gnt[0]) begin
            wr_pri_next = 1'b1;
        end else if (wr_gnt[1]) begin
            wr_pri_next = 1'b0;
        end

        // Saturate at all-ones instead of wrapping.
        if (conflict && (conflict_count_reg != {CNT_WIDTH{1'b1}})) begin
            conflict_count_next = conflict_count_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pri_reg         <= 1'b0;
            wr_pri_reg         <= 1'b0;
            resp_pend_reg      <= 2'b00;
            conflict_count_reg <= '0;
        end else begin
            rd_pri_reg         <= rd_pri_next;
            wr_pri_reg         <= wr_pri_next;
            resp_pend_reg      <= resp_pend_next;
            conflict_count_reg <= conflict_count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Response routing. The BRAM read data arrives one cycle after the grant,
    // which is exactly when resp_pend_reg names the requester that issued it.
    // Gating with reset drops a response whose grant preceded reset.
    // -------------------------------------------------------------------------
    assign resp_valid_0 = resp_pend_reg[0] & ~reset;
    assign resp_valid_1 = resp_pend_reg[1] & ~reset;
    assign resp_rdata_0 = resp_valid_0 ? bram_read_data : '0;
    assign resp_rdata_1 = resp_valid_1 ? bram_read_data : '0;

    assign conflict_count = conflict_count_reg;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Self-checking bench for bram_port_arbiter. It contains a behavioural
// simple-dual-port BRAM with forwarding, a directed vector table, hand-written
// reset/saturation sequences, and a randomized phase checked against a
// reference model of the arbitration rules. The counter width is reduced to
// 4 bits so that saturation is reached in a few cycles.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid_0, req_write_0, req_valid_1, req_write_1;
    logic [AW-1:0] req_addr_0, req_addr_1;
    logic [DW-1:0] req_wdata_0, req_wdata_1;
    logic          req_ready_0, req_ready_1;
    logic          resp_valid_0, resp_valid_1;
    logic [DW-1:0] resp_rdata_0, resp_rdata_1;
    logic          bram_read_enable, bram_write_enable;
    logic [AW-1:0] bram_read_address, bram_write_address;
    logic [DW-1:0] bram_read_data = '0;
    logic [DW-1:0] bram_write_data;
    logic [CW-1:0] conflict_count;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    bram_port_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid_0       (req_valid_0),
        .req_write_0       (req_write_0),
        .req_addr_0        (req_addr_0),
        .req_wdata_0       (req_wdata_0),
        .req_ready_0       (req_ready_0),
        .req_valid_1       (req_valid_1),
        .req_write_1       (req_write_1),
        .req_addr_1        (req_addr_1),
        .req_wdata_1       (req_wdata_1),
        .req_ready_1       (req_ready_1),
        .resp_valid_0      (resp_valid_0),
        .resp_rdata_0      (resp_rdata_0),
        .resp_valid_1      (resp_valid_1),
        .resp_rdata_1      (resp_rdata_1),
        .bram_read_enable  (bram_read_enable),
        .bram_read_address (bram_read_address),
        .bram_read_data    (bram_read_data),
        .bram_write_enable (bram_write_enable),
        .bram_write_address(bram_write_address),
        .bram_write_data   (bram_write_data),
        .conflict_count    (conflict_count)
    );

    // Behavioural BRAM: registered read, write data forwarded on same address.
    logic [DW-1:0] tb_mem [256] = '{default: '0};
    always @(posedge clock) begin
        if (bram_write_enable) tb_mem[bram_write_address] <= bram_write_data;
        if (bram_read_enable) begin
            if (bram_write_enable && (bram_write_address == bram_read_address))
                bram_read_data <= bram_write_data;
            else
                bram_read_data <= tb_mem[bram_read_address];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end else begin
            $display("ok   %s @%0t: %0h", nm, $time, act);
        end
    endtask

    task automatic drive(input logic v0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic v1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req_valid_0 = v0; req_write_0 = w0; req_addr_0 = a0; req_wdata_0 = d0;
        req_valid_1 = v1; req_write_1 = w1; req_addr_1 = a1; req_wdata_1 = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    // Holds reset for two edges with live requests on both inputs; everything
    // must stay quiet. Returns at posedge+1 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 8'h05, 32'h0, 1'b1, 1'b1, 8'h06, 32'h55);
        @(posedge clock); #1;
        @(posedge clock); #1;
        #4;
        chk("rst_ready0", 64'(req_ready_0), 64'd0);
        chk("rst_ready1", 64'(req_ready_1), 64'd0);
        chk("rst_re", 64'(bram_read_enable), 64'd0);
        chk("rst_we", 64'(bram_write_enable), 64'd0);
        chk("rst_raddr", 64'(bram_read_address), 64'd0);
        chk("rst_wdata", 64'(bram_write_data), 64'd0);
        chk("rst_rv0", 64'(resp_valid_0), 64'd0);
        chk("rst_rv1", 64'(resp_valid_1), 64'd0);
        chk("rst_cnt", 64'(conflict_count), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle();
    endtask

    typedef struct {
        logic          v0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          rdy0, rdy1, re, we, rv0, rv1;
        logic [DW-1:0] rd0, rd1;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tv [16];

    // Reference model state for the random phase
    typedef struct {
        bit            v;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    op_t           op [2];
    logic [DW-1:0] ref_mem [256];
    int            last_rd_winner, last_wr_winner, pend_req, model_cnt;
    logic [DW-1:0] pend_data;

    initial begin
        reset = 1'b1;
        idle();

        // ---------------- directed vector table -----------------------------
        //          v0    w0    a0     d0            v1    w1    a1     d1
        //          rdy0  rdy1  re    we    rv0   rv1   rd0           rd1           cnt
        tv[0]  = '{1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,
                   1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        4'd0};
        tv[1]  = '{1'b1,1'b1,8'h10,32'hDEADBEEF, 1'b0,1'b0,8'h00,32'h0,
                   1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        4'd0};
        tv[2]  = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h10,32'h0,
                   1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        4'd0};
        tv[3]  = '{1'b1,1'b1,8'h01,32'h11111111, 1'b0,1'b0,8'h00,32'h0,
                   1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,32'h0,        32'hDEADBEEF, 4'd0};
        tv[4]  = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b1,8'h02,32'h22222222,
                   1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        4'd0};
        tv[5]  = '{1'b1,1'b0,8'h01,32'h0,        1'b1,1'b0,8'h02,32'h0,
                   1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        4'd0};
        tv[6]  = '{1'b1,1'b0,8'h01,32'h0,        1'b1,1'b0,8'h02,32'h0,
                   1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,32'h11111111, 32'h0,        4'd1};
        tv[7]  = '{1'b1,1'b0,8'h01,32'h0,        1'b1,1'b0,8'h02,32'h0,
                   1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,32'h0,        32'h22222222, 4'd2};
        tv[8]  = '{1'b1,1'b0,8'h01,32'h0,        1'b1,1'b0,8'h02,32'h0,
                   1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,32'h11111111, 32'h0,        4'd3};
        tv[9]  = '{1'b1,1'b0,8'h20,32'h0,        1'b1,1'b1,8'h20,32'h12345678,
                   1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,32'h0,        32'h22222222, 4'd4};
        tv[10] = '{1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,
                   1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h12345678, 32'h0,        4'd4};
        tv[11] = '{1'b1,1'b1,8'h30,32'h0000000A, 1'b1,1'b1,8'h31,32'h0000000B,
                   1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        4'd4};
        tv[12] = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b1,8'h31,32'h0000000B,
                   1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        4'd5};
        tv[13] = '{1'b1,1'b0,8'h30,32'h0,        1'b1,1'b0,8'h31,32'h0,
                   1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        4'd5};
        tv[14] = '{1'b1,1'b0,8'h30,32'h0,        1'b0,1'b0,8'h00,32'h0,
                   1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,32'h0,        32'h0000000B, 4'd6};
        tv[15] = '{1'b0,1'b0,8'h00,32'h0,        1'b0,1'b0,8'h00,32'h0,
                   1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000000A, 32'h0,        4'd6};

        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].v0, tv[i].w0, tv[i].a0, tv[i].d0,
                  tv[i].v1, tv[i].w1, tv[i].a1, tv[i].d1);
            #4;
            chk($sformatf("tv%0d_ready0", i), 64'(req_ready_0), 64'(tv[i].rdy0));
            chk($sformatf("tv%0d_ready1", i), 64'(req_ready_1), 64'(tv[i].rdy1));
            chk($sformatf("tv%0d_re", i), 64'(bram_read_enable), 64'(tv[i].re));
            chk($sformatf("tv%0d_we", i), 64'(bram_write_enable), 64'(tv[i].we));
            chk($sformatf("tv%0d_rv0", i), 64'(resp_valid_0), 64'(tv[i].rv0));
            chk($sformatf("tv%0d_rv1", i), 64'(resp_valid_1), 64'(tv[i].rv1));
            chk($sformatf("tv%0d_rdata0", i), 64'(resp_rdata_0), 64'(tv[i].rd0));
            chk($sformatf("tv%0d_rdata1", i), 64'(resp_rdata_1), 64'(tv[i].rd1));
            chk($sformatf("tv%0d_cnt", i), 64'(conflict_count), 64'(tv[i].cnt));
            @(posedge clock); #1;
        end

        // ---------------- read to requester 1, then reset -------------------
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h10, 32'h0);
        #4;
        chk("rr_ready1", 64'(req_ready_1), 64'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #4;
        chk("rr_rv1_in_reset", 64'(resp_valid_1), 64'd0);
        chk("rr_rdata1_in_reset", 64'(resp_rdata_1), 64'd0);
        chk("rr_ready1_in_reset", 64'(req_ready_1), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
        #4;
        chk("rr_post_ready0", 64'(req_ready_0), 64'd1);
        chk("rr_post_ready1", 64'(req_ready_1), 64'd0);
        chk("rr_post_rv1", 64'(resp_valid_1), 64'd0);
        chk("rr_post_cnt", 64'(conflict_count), 64'd0);
        @(posedge clock); #1;
        #4;
        chk("rr_post_rv0", 64'(resp_valid_0), 64'd1);
        chk("rr_post_rdata0", 64'(resp_rdata_0), 64'h11111111);

        // ---------------- counter saturation --------------------------------
        // Contention continues for 20 more cycles; a wrapping counter would
        // land on 5, a saturating one stays at 15.
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
        end
        #4;
        chk("sat_cnt", 64'(conflict_count), 64'd15);
        drive(1'b1, 1'b1, 8'h40, 32'h1, 1'b1, 1'b1, 8'h41, 32'h2);
        @(posedge clock); #1;
        #4;
        chk("sat_cnt_hold", 64'(conflict_count), 64'd15);
        @(posedge clock); #1;

        // ---------------- randomized phase ----------------------------------
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        op[0] = '{1'b0, 1'b0, 8'h00, 32'h0};
        op[1] = '{1'b0, 1'b0, 8'h00, 32'h0};
        last_rd_winner = 1;   // so that requester 0 is preferred first
        last_wr_winner = 1;
        pend_req       = -1;
        pend_data      = '0;
        model_cnt      = 0;

        for (int cyc = 0; cyc < 300; cyc++) begin
            int            gr_rd, gr_wr;
            bit            rd0, rd1, wr0, wr1;
            logic [AW-1:0] e_ra, e_wa;
            logic [DW-1:0] e_wd;

            // New operations appear only when the previous one was accepted;
            // an unaccepted one is held unchanged. Random-area addresses
            // 0x80..0x87 are untouched by the earlier phases.
            for (int k = 0; k < 2; k++) begin
                if (!op[k].v && ($urandom_range(0, 3) != 0)) begin
                    op[k].v = 1'b1;
                    op[k].w = 1'($urandom_range(0, 1));
                    op[k].a = 8'h80 + 8'($urandom_range(0, 7));
                    op[k].d = $urandom;
                end
            end
            // Idle requesters present junk address/data; it must not leak out.
            drive(op[0].v, op[0].w, op[0].v ? op[0].a : 8'($urandom), op[0].d,
                  op[1].v, op[1].w, op[1].v ? op[1].a : 8'($urandom), op[1].d);
            #4;

            rd0 = op[0].v && !op[0].w;  rd1 = op[1].v && !op[1].w;
            wr0 = op[0].v &&  op[0].w;  wr1 = op[1].v &&  op[1].w;

            // Contention goes to whoever did not win that port most recently.
            gr_rd = -1;
            if (rd0 && rd1) gr_rd = (last_rd_winner == 0) ? 1 : 0;
            else if (rd0)   gr_rd = 0;
            else if (rd1)   gr_rd = 1;
            gr_wr = -1;
            if (wr0 && wr1) gr_wr = (last_wr_winner == 0) ? 1 : 0;
            else if (wr0)   gr_wr = 0;
            else if (wr1)   gr_wr = 1;

            e_ra = (gr_rd >= 0) ? op[gr_rd].a : 8'h00;
            e_wa = (gr_wr >= 0) ? op[gr_wr].a : 8'h00;
            e_wd = (gr_wr >= 0) ? op[gr_wr].d : 32'h0;

            chk("rnd_ready0", 64'(req_ready_0), 64'((gr_rd == 0) || (gr_wr == 0)));
            chk("rnd_ready1", 64'(req_ready_1), 64'((gr_rd == 1) || (gr_wr == 1)));
            chk("rnd_re", 64'(bram_read_enable), 64'(gr_rd >= 0));
            chk("rnd_raddr", 64'(bram_read_address), 64'(e_ra));
            chk("rnd_we", 64'(bram_write_enable), 64'(gr_wr >= 0));
            chk("rnd_waddr", 64'(bram_write_address), 64'(e_wa));
            chk("rnd_wdata", 64'(bram_write_data), 64'(e_wd));
            chk("rnd_rv0", 64'(resp_valid_0), 64'(pend_req == 0));
            chk("rnd_rv1", 64'(resp_valid_1), 64'(pend_req == 1));
            chk("rnd_rdata0", 64'(resp_rdata_0), 64'((pend_req == 0) ? pend_data : 32'h0));
            chk("rnd_rdata1", 64'(resp_rdata_1), 64'((pend_req == 1) ? pend_data : 32'h0));
            chk("rnd_cnt", 64'(conflict_count), 64'(model_cnt));

            // Effects of the coming clock edge
            if (gr_rd >= 0) begin
                pend_req  = gr_rd;
                pend_data = (gr_wr >= 0 && op[gr_wr].a == op[gr_rd].a)
                            ? op[gr_wr].d : ref_mem[op[gr_rd].a];
                last_rd_winner = gr_rd;
                op[gr_rd].v = 1'b0;
            end else begin
                pend_req = -1;
            end
            if (gr_wr >= 0) begin
                ref_mem[op[gr_wr].a] = op[gr_wr].d;
                last_wr_winner = gr_wr;
                op[gr_wr].v = 1'b0;
            end
            if ((rd0 && rd1) || (wr0 && wr1))
                model_cnt = (model_cnt == 15) ? 15 : model_cnt + 1;

            @(posedge clock); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
